div_unit: RTL and testbench

Iterative 32-bit integer divider serving the EXE stage for MIPS `DIV`/`DIVU`. It sits beside `exe`: it takes the forwarded operands already selected in EXE and holds the pipeline through the `stall` vector while it iterates. It then hands quotient and remainder to the HI/LO write path (`regfile_hilo` `i_lo`/`i_hi`) with a one-cycle write strobe. It uses a radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit_step.sv | 26 ++
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // One quotient bit is resolved per CALC cycle.
   localparam int DIV_CYCLES = 32;

   // Quotient returned for a zero divisor (the remainder is the raw dividend).
   localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

   // Bit of the pipeline stall vector driven by the divider's stall request
   // (EXE-stage requester).
   localparam int STALL_IDX_DIV = 3;

endpackage

// File: rtl/div_unit_if.sv
// Operand/result bundle between EXE and the divider.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             cancel;
   logic             stall_req;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;

   // EXE side: issues the divide and consumes the results.
   modport master (
      output start, signed_div, dividend, divisor, cancel,
      input  stall_req, done, hi, lo, busy
   );

   // Divider side.
   modport slave (
      input  start, signed_div, dividend, divisor, cancel,
      output stall_req, done, hi, lo, busy
   );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one bit,
// trial-subtract the divisor and take the quotient bit from the borrow.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;

   // Trial subtract one bit wider than the remainder so borrow is explicit.
   always_comb begin
      w_shift  = {i_rem, i_quo[WIDTH-1]};
      w_diff   = w_shift - {2'b00, i_divisor};
      w_borrow = w_diff[WIDTH+1];
      o_rem    = w_borrow ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
      o_quo    = {i_quo[WIDTH-2:0], ~w_borrow};
   end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit for the EXE stage. Stalls the pipeline while
// it iterates and presents quotient (lo) / remainder (hi) with a one-cycle
// done strobe for the HI/LO write path.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   div_unit_if.slave bus
);

   localparam int                CNT_W    = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

   div_state_t        r_state;
   div_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_count;
   logic [WIDTH:0]    r_rem;
   logic [WIDTH-1:0]  r_quo;
   logic [WIDTH-1:0]  r_dvsr;
   logic              r_qsign;
   logic              r_rsign;
   logic [WIDTH-1:0]  r_hi;
   logic [WIDTH-1:0]  r_lo;

   logic              w_go;
   logic              w_dvs_zero;
   logic              w_last;
   logic              w_dvd_neg;
   logic              w_dvs_neg;
   logic [WIDTH-1:0]  w_dvd_mag;
   logic [WIDTH-1:0]  w_dvs_mag;
   logic [WIDTH:0]    w_step_rem;
   logic [WIDTH-1:0]  w_step_quo;
   logic [WIDTH-1:0]  w_quo_fix;
   logic [WIDTH-1:0]  w_rem_fix;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .i_rem    (r_rem),
      .i_quo    (r_quo),
      .i_divisor(r_dvsr),
      .o_rem    (w_step_rem),
      .o_quo    (w_step_quo)
   );

   // Operand magnitudes, launch/finish conditions and result sign fix-up.
   // 0x8000_0000 negates to itself, which is its correct unsigned magnitude.
   always_comb begin
      w_go       = bus.start & ~bus.cancel;
      w_dvs_zero = (bus.divisor == '0);
      w_last     = (r_state == CALC) && (r_count == LAST_CNT);
      w_dvd_neg  = bus.signed_div & bus.dividend[WIDTH-1];
      w_dvs_neg  = bus.signed_div & bus.divisor[WIDTH-1];
      w_dvd_mag  = w_dvd_neg ? -bus.dividend : bus.dividend;
      w_dvs_mag  = w_dvs_neg ? -bus.divisor  : bus.divisor;
      w_quo_fix  = r_qsign ? -w_step_quo : w_step_quo;
      w_rem_fix  = r_rsign ? -w_step_rem[WIDTH-1:0] : w_step_rem[WIDTH-1:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; cancel overrides both launch and completion.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_go) begin
               w_state_nxt = w_dvs_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (bus.cancel) begin
         w_state_nxt = IDLE;
      end
   end

   // Datapath: operand capture, iteration, and result latch on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvsr  <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  if (w_dvs_zero) begin
                     r_lo <= WIDTH'(DIV_ZERO_LO);
                     r_hi <= bus.dividend;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= w_dvd_mag;
                     r_dvsr  <= w_dvs_mag;
                     r_qsign <= w_dvd_neg ^ w_dvs_neg;
                     r_rsign <= w_dvd_neg;
                     r_count <= '0;
                  end
               end
            end
            CALC: begin
               if (!bus.cancel) begin
                  r_rem   <= w_step_rem;
                  r_quo   <= w_step_quo;
                  r_count <= r_count + 1'b1;
                  if (w_last) begin
                     r_lo <= w_quo_fix;
                     r_hi <= w_rem_fix;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.done      = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.stall_req = bus.start & (r_state != DONE) & ~bus.cancel;
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus cancel/reset/back-to-back
// sequences, with hand-computed quotient/remainder and cycle counts.
module tb_div_unit;

   logic clk;
   logic reset;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(
      .WIDTH(32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] prev_lo = '0;
   logic [31:0] prev_hi = '0;

   typedef struct {
      string       name;
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] elo;
      logic [31:0] ehi;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called about 1 time unit after a rising edge with the DUT in IDLE.
   // Cycle 0 is the current cycle; outputs are sampled on falling edges.
   task automatic do_div(input string name, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input int elat, input bit keep_start);
      int lat;
      int seq_bad;
      int hold_bad;
      lat      = -1;
      seq_bad  = 0;
      hold_bad = 0;
      bus.start      = 1'b1;
      bus.signed_div = sg;
      bus.dividend   = a;
      bus.divisor    = b;
      for (int c = 0; c < 40 && lat < 0; c++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = c;
            if (bus.stall_req !== 1'b0 || bus.busy !== 1'b1) seq_bad++;
         end else begin
            if (bus.stall_req !== 1'b1) seq_bad++;
            if (bus.busy !== (c != 0)) seq_bad++;
            if (bus.lo !== prev_lo || bus.hi !== prev_hi) hold_bad++;
         end
         @(posedge clk);
         #1;
      end
      if (!keep_start) bus.start = 1'b0;
      chk({name, " latency"}, lat, elat);
      chk({name, " lo"}, bus.lo, elo);
      chk({name, " hi"}, bus.hi, ehi);
      chk({name, " stall/busy seq"}, seq_bad, 0);
      chk({name, " hi/lo hold"}, hold_bad, 0);
      prev_lo = elo;
      prev_hi = ehi;
   endtask

   task automatic idle_check(input string name);
      @(negedge clk);
      chk({name, " idle stall"}, {31'b0, bus.stall_req}, 32'd0);
      chk({name, " idle busy/done"}, {30'b0, bus.busy, bus.done}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen_done;
      int hold_bad;

      vecs[0]  = '{"divu 100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        33};
      vecs[1]  = '{"div -7/2",        1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
      vecs[2]  = '{"div 7/-2",        1'b1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        33};
      vecs[3]  = '{"div ovf",         1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       33};
      vecs[4]  = '{"divu ovf ops",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
      vecs[5]  = '{"divu by zero",    1'b0, 32'h1234_5678, 32'd0,       32'hFFFF_FFFF, 32'h1234_5678, 1};
      vecs[6]  = '{"div by zero",     1'b1, 32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFFF, 32'hFFFF_FFF9, 1};
      vecs[7]  = '{"divu max/1",      1'b0, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'd0,        33};
      vecs[8]  = '{"div -100/-7",     1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,      32'hFFFF_FFFE, 33};
      vecs[9]  = '{"divu 5/9",        1'b0, 32'd5,        32'd9,        32'd0,        32'd5,        33};
      vecs[10] = '{"divu deadbeef/16", 1'b0, 32'hDEAD_BEEF, 32'd16,     32'h0DEA_DBEE, 32'h0000_000F, 33};
      vecs[11] = '{"div min/2",       1'b1, 32'h8000_0000, 32'd2,       32'hC000_0000, 32'd0,        33};

      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.dividend   = '0;
      bus.divisor    = '0;
      bus.cancel     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      @(negedge clk);
      chk("reset lo", bus.lo, 32'd0);
      chk("reset hi", bus.hi, 32'd0);
      chk("reset done/busy/stall", {29'b0, bus.done, bus.busy, bus.stall_req}, 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         do_div(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b,
                vecs[i].elo, vecs[i].ehi, vecs[i].lat, 1'b0);
         idle_check(vecs[i].name);
      end

      // Cancel in CALC cycle 10: no done, results untouched, then a clean divide.
      bus.start      = 1'b1;
      bus.signed_div = 1'b0;
      bus.dividend   = 32'd1000;
      bus.divisor    = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      @(negedge clk);
      chk("cancel stall masked", {31'b0, bus.stall_req}, 32'd0);
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      bus.start  = 1'b0;
      @(negedge clk);
      chk("cancel busy", {31'b0, bus.busy}, 32'd0);
      seen_done = 0;
      hold_bad  = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done) seen_done++;
         if (bus.lo !== prev_lo || bus.hi !== prev_hi) hold_bad++;
         @(negedge clk);
      end
      chk("cancel no done", seen_done, 0);
      chk("cancel hi/lo held", hold_bad, 0);
      @(posedge clk);
      #1;
      do_div("divu 1000/3 after cancel", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 1'b0);
      idle_check("after cancel");

      // Reset in CALC cycle 20.
      bus.start      = 1'b1;
      bus.signed_div = 1'b1;
      bus.dividend   = 32'hFFFF_FFCE;
      bus.divisor    = 32'd3;
      repeat (20) @(posedge clk);
      #1;
      reset     = 1'b1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midreset lo", bus.lo, 32'd0);
      chk("midreset hi", bus.hi, 32'd0);
      chk("midreset done/busy", {30'b0, bus.done, bus.busy}, 32'd0);
      prev_lo = '0;
      prev_hi = '0;
      @(posedge clk);
      #1;

      // Back-to-back: start stays high into the cycle after DONE.
      do_div("div -50/3", 1'b1, 32'hFFFF_FFCE, 32'd3, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 33, 1'b1);
      do_div("b2b divu 81/9", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 33, 1'b1);
      do_div("b2b div 50/-7", 1'b1, 32'd50, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1, 33, 1'b0);
      idle_check("after b2b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
